tt_um_accelshark_psg_i2s_rx: RTL and testbench

Stereo I2S receiver (slave) for the PSG audio path: accepts externally driven SCLK/LRCK/SDATA, oversamples them in the system clock domain, and delivers parallel left/right sample pairs with a one-cycle valid strobe. It is the capture end of the PSG's 8-bit I2S output link. It serves loopback verification and external audio injection into the mixer.

---
 rtl/tt_um_accelshark_psg_pkg.sv | 14 +
 rtl/tt_um_accelshark_psg_sync_edge.sv | 35 +++
 rtl/tt_um_accelshark_psg_i2s_rx.sv | 142 ++++++++++++++
 tb/tb_tt_um_accelshark_psg_i2s_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_accelshark_psg_pkg.sv
// Shared definitions for the PSG I2S receive path.
// Receiver state encoding and default geometry.
package tt_um_accelshark_psg_pkg;

   localparam int DEF_WIDTH       = 8;
   localparam int DEF_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } rx_state_t;

endpackage

// File: rtl/tt_um_accelshark_psg_sync_edge.sv
// Multi-flop synchronizer for an async input with
// registered rise/fall pulses one cycle after the synced level.
module tt_um_accelshark_psg_sync_edge
   import tt_um_accelshark_psg_pkg::*;
#(
   parameter int STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic              level;

   assign level = sync_q[STAGES-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= level;
         rise   <= level & ~prev_q;
         fall   <= ~level & prev_q;
      end
   end

endmodule

// File: rtl/tt_um_accelshark_psg_i2s_rx.sv
// Stereo I2S slave receiver: oversampled SCLK/LRCK/SDATA to L/R pairs.
// Define ACCELSHARK_I2S_RX_PHILIPS_EN for one-bit-delayed Philips framing.
module tt_um_accelshark_psg_i2s_rx
   import tt_um_accelshark_psg_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             i2s_sclk,
   input  logic             i2s_lrck,
   input  logic             i2s_sdata,
   output logic [WIDTH-1:0] sample_l,
   output logic [WIDTH-1:0] sample_r,
   output logic             sample_valid,
   output logic             frame_err
);

`ifdef ACCELSHARK_I2S_RX_PHILIPS_EN
   localparam bit PHILIPS = 1'b1;
`else
   localparam bit PHILIPS = 1'b0;
`endif

   localparam int CW = $clog2(WIDTH + 1);

   logic                   sclk_fall;
   logic                   unused_sclk_rise;
   logic                   lrck_rise;
   logic                   lrck_fall;
   logic [SYNC_STAGES-1:0] sd_q;
   logic                   sdata_s;

   rx_state_t              state, state_n;
   logic [WIDTH-1:0]       shift_q, shift_n;
   logic [WIDTH-1:0]       left_q;
   logic [CW-1:0]          cnt_q, cnt_n;
   logic                   skip_q, skip_n;
   logic                   short_w;

   tt_um_accelshark_psg_sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_sclk (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (i2s_sclk),
      .rise  (unused_sclk_rise),
      .fall  (sclk_fall)
   );

   tt_um_accelshark_psg_sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_lrck (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (i2s_lrck),
      .rise  (lrck_rise),
      .fall  (lrck_fall)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) sd_q <= '0;
      else        sd_q <= {sd_q[SYNC_STAGES-2:0], i2s_sdata};
   end

   assign sdata_s = sd_q[SYNC_STAGES-1];
   assign short_w = cnt_q < CW'(WIDTH);

   always_comb begin
      state_n = state;
      unique case (state)
         ST_SYNC:  if (lrck_fall) state_n = ST_LEFT;
         ST_LEFT:  if (lrck_rise) state_n = ST_RIGHT;
         ST_RIGHT: if (lrck_fall) state_n = ST_LEFT;
         default:  state_n = ST_SYNC;
      endcase
   end

   // lrck edge clears first, so a coincident sclk fall is bit 0
   always_comb begin
      shift_n = shift_q;
      cnt_n   = cnt_q;
      skip_n  = skip_q;
      if (lrck_rise || lrck_fall) begin
         shift_n = '0;
         cnt_n   = '0;
         skip_n  = PHILIPS;
      end
      if (sclk_fall && state_n != ST_SYNC) begin
         if (skip_n) begin
            skip_n = 1'b0;
         end else if (cnt_n < CW'(WIDTH)) begin
            for (int i = 0; i < WIDTH; i++) begin
               if (cnt_n == CW'(WIDTH - 1 - i))
                  shift_n[i] = sdata_s;
            end
            cnt_n = cnt_n + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_SYNC;
         shift_q      <= '0;
         cnt_q        <= '0;
         skip_q       <= 1'b0;
         left_q       <= '0;
         sample_l     <= '0;
         sample_r     <= '0;
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
      end else if (!ena) begin
         state        <= ST_SYNC;
         shift_q      <= '0;
         cnt_q        <= '0;
         skip_q       <= 1'b0;
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         state        <= state_n;
         shift_q      <= shift_n;
         cnt_q        <= cnt_n;
         skip_q       <= skip_n;
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
         if (state == ST_LEFT && lrck_rise) begin
            left_q    <= shift_q;
            frame_err <= short_w;
         end
         if (state == ST_RIGHT && lrck_fall) begin
            sample_l     <= left_q;
            sample_r     <= shift_q;
            sample_valid <= 1'b1;
            frame_err    <= short_w;
         end
      end
   end

endmodule

// File: tb/tb_tt_um_accelshark_psg_i2s_rx.sv
// Bench for the PSG I2S receiver: table frames, corner sequences
// and random frames checked against a word-level model.
module tb_tt_um_accelshark_psg_i2s_rx;

   localparam int W = 8;
`ifdef ACCELSHARK_I2S_RX_PHILIPS_EN
   localparam int DLY = 1;
`else
   localparam int DLY = 0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ena = 1'b1;
   logic         sclk = 1'b0;
   logic         lrck = 1'b1;
   logic         sdata = 1'b0;
   logic [W-1:0] sample_l;
   logic [W-1:0] sample_r;
   logic         sample_valid;
   logic         frame_err;

   always #5 clk = ~clk;

   tt_um_accelshark_psg_i2s_rx #(
      .WIDTH       (W),
      .SYNC_STAGES (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .i2s_sclk     (sclk),
      .i2s_lrck     (lrck),
      .i2s_sdata    (sdata),
      .sample_l     (sample_l),
      .sample_r     (sample_r),
      .sample_valid (sample_valid),
      .frame_err    (frame_err)
   );

   typedef struct {
      logic         v;
      logic         e;
      logic [W-1:0] l;
      logic [W-1:0] r;
   } ev_t;

   typedef struct {
      int           ln;
      logic [15:0]  ld;
      int           rn;
      logic [15:0]  rd;
      logic [W-1:0] xl;
      logic [W-1:0] xr;
      logic         xel;
      logic         xer;
   } vec_t;

   int  vectors = 0;
   int  miscompares = 0;
   int  cyc = 0;
   int  fall_cyc = 0;
   ev_t evq[$];
   int  evcyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (sample_valid || frame_err) begin
         evq.push_back('{sample_valid, frame_err,
                         sample_l, sample_r});
         evcyc.push_back(cyc);
      end
   end

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h",
                  name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // transmitter updates lrck/sdata on sclk rise
   task automatic send_bit(input logic lr, input logic b);
      if (lrck == 1'b1 && lr == 1'b0) fall_cyc = cyc;
      sclk  = 1'b1;
      lrck  = lr;
      sdata = b;
      wait_clks(8);
      sclk = 1'b0;
      wait_clks(8);
   endtask

   task automatic send_half(input logic lr, input int n,
                            input logic [15:0] d);
      if (DLY != 0) send_bit(lr, ~d[n-1]);
      for (int i = n - 1; i >= 0; i--) send_bit(lr, d[i]);
   endtask

   task automatic send_frame(input int ln, input logic [15:0] ld,
                             input int rn, input logic [15:0] rd);
      send_half(1'b0, ln, ld);
      send_half(1'b1, rn, rd);
   endtask

   task automatic preamble();
      send_bit(1'b1, 1'b0);
      ena = 1'b0;
      wait_clks(2);
      ena = 1'b1;
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      evq.delete();
      evcyc.delete();
   endtask

   task automatic terminate();
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      wait_clks(2);
   endtask

   task automatic chk_events(input string tag, input ev_t exp[$]);
      chk($sformatf("%s count", tag), evq.size(), exp.size());
      for (int i = 0; i < exp.size() && i < evq.size(); i++) begin
         chk($sformatf("%s[%0d] valid", tag, i), evq[i].v, exp[i].v);
         chk($sformatf("%s[%0d] err", tag, i), evq[i].e, exp[i].e);
         if (exp[i].v) begin
            chk($sformatf("%s[%0d] l", tag, i), evq[i].l, exp[i].l);
            chk($sformatf("%s[%0d] r", tag, i), evq[i].r, exp[i].r);
         end
      end
   endtask

   // first W bits sent MSB first, zero-filled when short
   function automatic logic [W-1:0] model_word(input int n,
                                               input logic [15:0] d);
      logic [31:0] x;
      x = 32'(d);
      if (n >= W) return W'(x >> (n - W));
      return W'(x << (W - n));
   endfunction

   initial begin
      vec_t        tbl[6];
      ev_t         exp_q[$];
      int          lat;
      int          ln, rn;
      logic [15:0] ld, rd;

      tbl[0] = '{8,  16'h00A5, 8,  16'h003C, 8'hA5, 8'h3C, 1'b0, 1'b0};
      tbl[1] = '{8,  16'h0081, 8,  16'h007E, 8'h81, 8'h7E, 1'b0, 1'b0};
      tbl[2] = '{5,  16'h0016, 8,  16'h00FF, 8'hB0, 8'hFF, 1'b1, 1'b0};
      tbl[3] = '{12, 16'h05A3, 12, 16'h0C3F, 8'h5A, 8'hC3, 1'b0, 1'b0};
      tbl[4] = '{8,  16'h0012, 8,  16'h00EF, 8'h12, 8'hEF, 1'b0, 1'b0};
      tbl[5] = '{8,  16'h00C6, 3,  16'h0005, 8'hC6, 8'hA0, 1'b0, 1'b1};

      wait_clks(5);
      rst_n = 1'b1;
      wait_clks(1);
      chk("reset sample_l", sample_l, 0);
      chk("reset sample_r", sample_r, 0);
      chk("reset valid", sample_valid, 0);
      chk("reset frame_err", frame_err, 0);

      // table frames, back to back
      preamble();
      for (int i = 0; i < 6; i++)
         send_frame(tbl[i].ln, tbl[i].ld, tbl[i].rn, tbl[i].rd);
      terminate();
      exp_q.delete();
      for (int i = 0; i < 6; i++) begin
         if (tbl[i].xel) exp_q.push_back('{1'b0, 1'b1, 8'h0, 8'h0});
         exp_q.push_back('{1'b1, tbl[i].xer, tbl[i].xl, tbl[i].xr});
      end
      chk_events("table", exp_q);
      lat = (evcyc.size() > 0) ? evcyc[evcyc.size()-1] - fall_cyc : -1;
      chk("valid latency", 32'(lat), 4);

      // reset in the middle of a right word
      preamble();
      send_half(1'b0, 8, 16'h00A5);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
      rst_n = 1'b0;
      wait_clks(3);
      rst_n = 1'b1;
      wait_clks(1);
      chk("midrst sample_l", sample_l, 0);
      chk("midrst sample_r", sample_r, 0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      send_frame(8, 16'h0081, 8, 16'h007E);
      chk("midrst hold l", sample_l, 0);
      chk("midrst quiet", evq.size(), 0);
      terminate();
      exp_q.delete();
      exp_q.push_back('{1'b1, 1'b0, 8'h81, 8'h7E});
      chk_events("midrst", exp_q);

      // ena low for three frames
      preamble();
      send_frame(8, 16'h0011, 8, 16'h0022);
      terminate();
      ena = 1'b0;
      for (int i = 0; i < 3; i++)
         send_frame(8, 16'($urandom), 8, 16'($urandom));
      send_bit(1'b0, 1'b0);
      chk("ena quiet", evq.size(), 1);
      chk("ena hold l", sample_l, 8'h11);
      chk("ena hold r", sample_r, 8'h22);
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b0);
      ena = 1'b1;
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b1);
      send_frame(8, 16'h0033, 8, 16'h0044);
      send_frame(8, 16'h0055, 8, 16'h0066);
      terminate();
      exp_q.delete();
      exp_q.push_back('{1'b1, 1'b0, 8'h11, 8'h22});
      exp_q.push_back('{1'b1, 1'b0, 8'h33, 8'h44});
      exp_q.push_back('{1'b1, 1'b0, 8'h55, 8'h66});
      chk_events("ena", exp_q);

      // random frame lengths and contents
      preamble();
      exp_q.delete();
      for (int i = 0; i < 20; i++) begin
         ln = $urandom_range(1, 12);
         rn = $urandom_range(1, 12);
         ld = 16'($urandom);
         rd = 16'($urandom);
         send_frame(ln, ld, rn, rd);
         if (ln < W) exp_q.push_back('{1'b0, 1'b1, 8'h0, 8'h0});
         exp_q.push_back('{1'b1, rn < W,
                           model_word(ln, ld), model_word(rn, rd)});
      end
      terminate();
      chk_events("random", exp_q);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
